nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL request a new addition; sampled only when ready=1.
REQ-005 A  input  W  SHALL be operand A, sampled with start.
REQ-006 B  input  W  SHALL be operand B, sampled with start.
REQ-007 ready  output  1  SHALL be high in IDLE and DONE: block can accept start.
REQ-008 busy  output  1  SHALL be high in RUN.
REQ-009 done  output  1  SHALL pulse high for exactly one cycle when S/Carry become valid.
REQ-010 S  output  W  SHALL be the registered sum.
REQ-011 Carry  output  1  SHALL be the registered carry-out of the MSB slice.

Function
REQ-012 Datapath SHALL contain exactly one 4-bit carry-lookahead slice (P=a^b, G=a&b, 4-level carry chain), time-shared across all nibbles.
REQ-013 FSM SHALL have states IDLE, RUN, DONE; encoding is implementation choice.
REQ-014 IDLE: start=1 -> latch A, B into operand registers, clear nibble counter idx to 0, load carry register with carry-in (REQ-029/030), go to RUN.
REQ-015 RUN: each cycle, slice adds A[idx], B[idx] and carry register; write the result into S[4*idx+3:4*idx]; carry register <= slice carry-out; idx <= idx+1.
REQ-016 RUN: when idx = NIBBLES-1, that cycle's carry-out SHALL load Carry and FSM SHALL go to DONE; idx does not wrap past NIBBLES-1.
REQ-017 Latency: start sampled at edge k -> RUN for edges k+1..k+NIBBLES -> done=1 in the cycle after edge k+NIBBLES.
REQ-018 DONE lasts one cycle: start=1 -> behave as REQ-014 (back-to-back, no IDLE bubble); else -> IDLE.
REQ-019 start while busy=1 SHALL be ignored; operands, idx, and result unaffected.
REQ-020 S and Carry SHALL hold the last completed result from DONE until the next accepted start; during RUN, S nibbles update progressively and are not valid until done.
REQ-021 A/B changes after acceptance SHALL NOT affect the running operation.
REQ-022 Result SHALL equal (A + B + cin) mod 2^W, with Carry = bit W, for all operand values.

Reset
REQ-023 rst=1 at any edge SHALL force IDLE, regardless of state.
REQ-024 Reset values: ready=1, busy=0, done=0, S=0, Carry=0, idx=0, carry register=0, operand registers=0.
REQ-025 rst mid-RUN SHALL abort the operation with no done pulse; the partial result is discarded (S=0).
REQ-026 rst and start asserted together: rst wins; start is ignored.
REQ-027 First start SHALL be accepted in the cycle after rst deasserts.
REQ-028 No output SHALL be X after the first reset edge.

Configuration
REQ-029 With macro NIBBLE_ADD_SEQ_CIN_EN defined: extra port Cin  input  1, sampled with start, SHALL seed the carry register for nibble 0.
REQ-030 Without NIBBLE_ADD_SEQ_CIN_EN: no Cin port; carry into nibble 0 SHALL be constant 0.

Verification (NIBBLES=4, W=16)
REQ-031 A=0x1234, B=0x4321, start 1 cycle -> busy 4 cycles, done 1 cycle, S=0x5555, Carry=0.
REQ-032 A=0xFFFF, B=0x0001 -> carry ripples across all 4 nibbles; S=0x0000, Carry=1, done exactly 5 cycles after the start edge.
REQ-033 Start 0x00F0+0x0010, re-pulse start with 0xAAAA/0x5555 while busy -> second start ignored; S=0x0100, Carry=0.
REQ-034 Start held high continuously with new operands each acceptance -> accepted in every DONE cycle; one done per 5 cycles (4 RUN + 1 DONE); no IDLE between operations.
REQ-035 rst asserted in 2nd RUN cycle of 0xFFFF+0xFFFF -> IDLE next cycle, no done, S=0, Carry=0, ready=1.
REQ-036 CIN_EN build: A=0xFFFF, B=0x0000, Cin=1 -> S=0x0000, Carry=1; non-CIN build, same A/B -> S=0xFFFF, Carry=0.

Source files
------------

// File: rtl/nibble_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : nibble_add_seq
// Description : Sequential W-bit adder (W = 4*NIBBLES). A single 4-bit
//               carry-lookahead slice is time-shared across all nibbles,
//               one nibble per clock, LSB nibble first.
//               Optional macro NIBBLE_ADD_SEQ_CIN_EN adds a Cin port that
//               seeds the carry into nibble 0 (otherwise carry-in is 0).
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
`ifdef NIBBLE_ADD_SEQ_CIN_EN
  input  logic                   Cin,
`endif
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   S,
  output logic                   Carry
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

  // Elaboration-time guard on the supported slice count
  if ((NIBBLES < 2) || (NIBBLES > 16)) begin : g_bad_nibbles
    $error("nibble_add_seq: NIBBLES must be in 2..16");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       s_q,     s_d;
  logic               cout_q,  cout_d;
  logic               ready_q, ready_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               w_cin;
  logic [IDX_W+1:0]   w_base;
  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;
  logic [3:0]         w_p;
  logic [3:0]         w_g;
  logic [4:0]         w_c;
  logic [3:0]         w_sum;

`ifdef NIBBLE_ADD_SEQ_CIN_EN
  assign w_cin = Cin;
`else
  assign w_cin = 1'b0;
`endif

  // Bit offset of the nibble currently being processed
  assign w_base  = {idx_q, 2'b00};
  assign w_a_nib = a_q[w_base +: 4];
  assign w_b_nib = b_q[w_base +: 4];

  // The one shared 4-bit carry-lookahead slice; carry-in comes from the
  // carry register so consecutive nibbles chain through time.
  assign w_p    = w_a_nib ^ w_b_nib;
  assign w_g    = w_a_nib & w_b_nib;
  assign w_c[0] = carry_q;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_sum  = w_p ^ w_c[3:0];

  // Next-state and datapath update; DONE accepts start exactly like IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = '0;
          carry_d = w_cin;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_d[w_base +: 4] = w_sum;
        carry_d          = w_c[4];
        if (idx_q == c_last_idx) begin
          cout_d  = w_c[4];
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they leave a flop
  always_comb begin
    ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign Carry = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_add_seq
// Description : Directed self-checking bench for nibble_add_seq, NIBBLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_add_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] S;
  logic        Carry;

  int vectors;
  int miscompares;

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef NIBBLE_ADD_SEQ_CIN_EN
    .Cin   (Cin),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Carry (Carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen (bounded); n = edges waited, bc = busy samples
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 16'h1111; B = 16'h2222;
    step();
    step();
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++;
    if (S !== 16'h0000 || Carry !== 1'b0) begin
      miscompares++; $display("FAIL reset_result: got S=%h C=%b expected S=0000 C=0", S, Carry);
    end
    rst = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int n, bc;
    A = 16'h1234; B = 16'h4321; start = 1'b1;
    step();
    start = 1'b0; A = 16'hFFFF; B = 16'hFFFF;  // must not disturb the running op
    wait_done(n, bc);
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d expected 4", n); end
    vectors++;
    if (bc !== 4) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
    vectors++;
    if (S !== 16'h5555 || Carry !== 1'b0) begin
      miscompares++; $display("FAIL basic_sum: got S=%h C=%b expected S=5555 C=0", S, Carry);
    end
    step();
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_done_one_cycle: got done=%b ready=%b busy=%b expected 0 1 0", done, ready, busy);
    end
    vectors++;
    if (S !== 16'h5555) begin miscompares++; $display("FAIL basic_hold: got %h expected 5555", S); end
  endtask

  task automatic test_ripple();
    int n, bc;
    A = 16'hFFFF; B = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n, bc);
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL ripple_latency: got %0d expected 4", n); end
    vectors++;
    if (S !== 16'h0000 || Carry !== 1'b1) begin
      miscompares++; $display("FAIL ripple_sum: got S=%h C=%b expected S=0000 C=1", S, Carry);
    end
    step();
  endtask

  task automatic test_ignore_busy();
    int n, bc;
    A = 16'h00F0; B = 16'h0010; start = 1'b1;
    step();
    start = 1'b0;
    step();
    A = 16'hAAAA; B = 16'h5555; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n, bc);
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 2", n); end
    vectors++;
    if (S !== 16'h0100 || Carry !== 1'b0) begin
      miscompares++; $display("FAIL ignore_sum: got S=%h C=%b expected S=0100 C=0", S, Carry);
    end
    step();
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL ignore_idle: got ready=%b busy=%b expected 1 0", ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [3] = '{16'h1111, 16'h8000, 16'hABCD};
    logic [15:0] tb [3] = '{16'h2222, 16'h8000, 16'h1234};
    logic [15:0] ts [3] = '{16'h3333, 16'h0000, 16'hBE01};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    int n, bc;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = ta[i]; B = tb[i];
      step();
      vectors++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
        miscompares++; $display("FAIL b2b_accept_%0d: got busy=%b ready=%b expected 1 0", i, busy, ready);
      end
      wait_done(n, bc);
      vectors++;
      if (n !== 4) begin miscompares++; $display("FAIL b2b_latency_%0d: got %0d expected 4", i, n); end
      vectors++;
      if (S !== ts[i] || Carry !== tc[i]) begin
        miscompares++; $display("FAIL b2b_sum_%0d: got S=%h C=%b expected S=%h C=%b", i, S, Carry, ts[i], tc[i]);
      end
      vectors++;
      if (ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, ready); end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int n, bc;
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL abort_state: got ready=%b busy=%b done=%b expected 1 0 0", ready, busy, done);
    end
    vectors++;
    if (S !== 16'h0000 || Carry !== 1'b0) begin
      miscompares++; $display("FAIL abort_result: got S=%h C=%b expected S=0000 C=0", S, Carry);
    end
    rst = 1'b0; A = 16'h0F0F; B = 16'h0101; start = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL post_reset_accept: got busy=%b expected 1", busy); end
    start = 1'b0;
    wait_done(n, bc);
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 4", n); end
    vectors++;
    if (S !== 16'h1010 || Carry !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_sum: got S=%h C=%b expected S=1010 C=0", S, Carry);
    end
    step();
  endtask

  task automatic test_cin();
    int n, bc;
    A = 16'hFFFF; B = 16'h0000; Cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0; Cin = 1'b0;
    wait_done(n, bc);
`ifdef NIBBLE_ADD_SEQ_CIN_EN
    vectors++;
    if (S !== 16'h0000 || Carry !== 1'b1) begin
      miscompares++; $display("FAIL cin_sum: got S=%h C=%b expected S=0000 C=1", S, Carry);
    end
`else
    vectors++;
    if (S !== 16'hFFFF || Carry !== 1'b0) begin
      miscompares++; $display("FAIL cin_sum: got S=%h C=%b expected S=FFFF C=0", S, Carry);
    end
`endif
    step();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_cin();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
